// File: rtl/wishbone_pkg.sv
// Shared Wishbone bus types plus the IRQ chain vector type, used by the
// config-space block that drives the chain and by the sink that terminates it.
package wishbone_pkg;

  localparam int WB_ADR_WID = 32;
  localparam int WB_DAT_WID = 32;
  localparam int WB_SEL_WID = WB_DAT_WID / 8;

  typedef logic [WB_ADR_WID-1:0] wb_adr_t;
  typedef logic [WB_DAT_WID-1:0] wb_dat_t;
  typedef logic [WB_SEL_WID-1:0] wb_sel_t;

  typedef struct packed {
    logic    cyc;
    logic    stb;
    logic    we;
    wb_adr_t adr;
    wb_dat_t dat;
    wb_sel_t sel;
  } wb_req_t;

  typedef struct packed {
    logic    ack;
    logic    err;
    logic    stall;
    wb_dat_t dat;
  } wb_rsp_t;

  localparam wb_req_t WB_REQ_IDLE = '{cyc: 1'b0, stb: 1'b0, we: 1'b0,
                                      adr: '0, dat: '0, sel: '0};
  localparam wb_rsp_t WB_RSP_IDLE = '{ack: 1'b0, err: 1'b0, stall: 1'b0, dat: '0};

  // One chain word per cycle; an all-zero word means no interrupt this cycle.
  localparam int IRQ_VECT_WID = 16;
  typedef logic [IRQ_VECT_WID-1:0] irq_vect_t;
  localparam irq_vect_t IRQ_CHAIN_IDLE = 16'h0000;

  function automatic logic irq_vect_valid(input irq_vect_t v);
    return v != IRQ_CHAIN_IDLE;
  endfunction

endpackage

// File: rtl/irq_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the occupancy counter is the only
// full/empty discriminator, so the pointers are plain log2(DEPTH)-bit wrappers.
module irq_sync_fifo #(
  parameter int WID   = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WID-1:0]           wdata_i,
  input  logic                     pop_i,
  output logic [WID-1:0]           rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WID-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok;
  logic           pop_ok;

  // A pop is only honoured with data present; a push into a full FIFO is only
  // honoured when the same cycle frees the head slot.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CNT_FULL) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/irq_chain_sink.sv
// Terminates the IRQ daisy chain: captures non-zero vectors into a FWFT queue,
// counts vectors lost to overflow and raises a level interrupt while non-empty.
module irq_chain_sink
  import wishbone_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DROP_WID = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [15:0]              irq_chain_i,
  input  logic                     en_i,
  output logic [15:0]              vec_o,
  output logic                     vec_valid_o,
  input  logic                     vec_ready_i,
  output logic                     irq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [DROP_WID-1:0]      drop_cnt_o,
  input  logic                     drop_clr_i
);

  // Handshake: vec_o transfers on a cycle where vec_valid_o && vec_ready_i;
  // while vec_valid_o is high and vec_ready_i low, vec_o holds its value.
  // vec_ready_i has no effect while vec_valid_o is low.

  irq_vect_t                 chain_w;
  logic                      push_req;
  logic                      pop_req;
  logic                      drop;
  logic                      fifo_full;
  logic                      fifo_valid;
  logic [DROP_WID-1:0]       drop_cnt_q, drop_cnt_d;

  assign chain_w  = irq_vect_t'(irq_chain_i);
  assign push_req = en_i && irq_vect_valid(chain_w);
  assign pop_req  = fifo_valid && vec_ready_i;
  // Only a full queue with no pop in the same cycle loses the word.
  assign drop     = push_req && fifo_full && !pop_req;

  irq_sync_fifo #(
    .WID   (IRQ_VECT_WID),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_req),
    .wdata_i (chain_w),
    .pop_i   (pop_req),
    .rdata_o (vec_o),
    .valid_o (fifo_valid),
    .count_o (count_o),
    .full_o  (fifo_full),
    .empty_o (empty_o)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr_i) begin
      drop_cnt_d = drop ? DROP_WID'(1) : '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign vec_valid_o = fifo_valid;
  assign irq_o       = fifo_valid;
  assign full_o      = fifo_full;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
